pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage in-order single-issue pipeline (IF, OF, EX, MEM, WB).
- Drives the stall and flush inputs of the IF stage and inter-stage pipe registers, which are currently tied off.
- Tracks in-flight register writes in a scoreboard to resolve RAW/WAW hazards.
- Sequences multi-cycle data-memory waits and branch-redirect flushes; exports stall statistics.

Parameters:
- NREGS, 32, architectural register count; x0 is never tracked.
- MEM_TIMEOUT, 64, max MEM_WAIT cycles before the sticky error is raised.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- of_valid  in  1  OF holds a valid instruction for issue
- of_rs1, of_rs2  in  5 each  OF source registers
- of_rs1_used, of_rs2_used  in  1 each  source actually read
- of_rd  in  5  OF destination register
- of_rd_wr  in  1  instruction writes rd
- ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle
- mem_req  in  1  MEM stage has a load/store this cycle
- mem_ready  in  1  data memory completes the access this cycle
- wb_valid, wb_rd_wr  in  1 each  WB retiring and writing
- wb_rd  in  5  WB destination register
- stall_front  out  1  hold IF, IF/OF and OF/EX pipes
- stall_back  out  1  hold the EX/MEM pipes (wb, mem, ctrl)
- bubble_ofex  out  1  load NOP into OF/EX
- bubble_memwb  out  1  load NOP into MEM/WB
- flush_ifof, flush_ofex  out  1 each  squash younger instructions
- issue  out  1  OF instruction accepted into EX this cycle
- scoreboard  out  NREGS  pending-write bits
- mem_timeout  out  1  sticky error
- stall_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset is asynchronous and active-low on resetn, single clock clk. Reset values: scoreboard=0, state=RUN, wait counter=0, mem_timeout=0, both counters=0.
- Reset mid-operation (e.g. during MEM_WAIT) returns the FSM to RUN and clears the scoreboard immediately.
- All stall, bubble, flush and issue outputs are combinational from state plus inputs. During reset they are 0.
- FSM states:
  - RUN to MEM_WAIT when mem_req & !mem_ready.
  - MEM_WAIT to RUN on the cycle mem_ready=1.
  - No other transitions.
- mem_stall = (state==RUN & mem_req & !mem_ready) | (state==MEM_WAIT & !mem_ready).
- When mem_stall is 1: stall_front=1, stall_back=1, bubble_memwb=1, issue=0, and flushes are suppressed.
- ex_branch_taken is held stable while EX is frozen, so a deferred flush fires on the release cycle.
- Wait counter: increments each MEM_WAIT cycle and clears on exit. When it reaches MEM_TIMEOUT, mem_timeout is set and holds until reset. The FSM keeps waiting.
- Flush (no mem_stall, ex_branch_taken=1): flush_ifof=1, flush_ofex=1, issue=0, no scoreboard set. A flush overrides a hazard stall in the same cycle.
- Hazard, evaluated only when of_valid & no mem_stall & no flush:
  - raw = (of_rs1_used & rs1!=0 & sb[rs1]) | (of_rs2_used & rs2!=0 & sb[rs2]).
  - waw = of_rd_wr & rd!=0 & sb[rd].
  - A register being cleared by WB this same cycle counts as not pending, because the regfile is write-through.
  - raw | waw gives stall_front=1 and bubble_ofex=1.
  - stall_back=0, so older instructions drain.
- issue = of_valid & no mem_stall & no flush & no hazard.
- Scoreboard update per cycle:
  - Clear sb[wb_rd] if wb_valid & wb_rd_wr & wb_rd!=0.
  - Then set sb[of_rd] if issue & of_rd_wr & of_rd!=0.
  - Set wins on the same index.
  - WAW stalling guarantees at most one pending writer per register, so a single bit suffices.
- Counters:
  - stall_cnt increments on each cycle with stall_front=1.
  - flush_cnt increments on each flush cycle.
  - Both wrap modulo 2^CNT_W.
- Output priority: reset > mem_stall > flush > hazard > issue.

Test Plan:
- Issue x5 write (of_rd=5), next cycle of_rs1=5 used → stall_front=1, bubble_ofex=1 until WB retires x5. Issue occurs in the WB cycle itself; sb[5] ends at 0.
- of_rd=0, of_rd_wr=1 issued, then of_rs1=0 → no stall, scoreboard stays 0.
- mem_req=1, mem_ready=0 for 3 cycles then 1 → stall_front/stall_back/bubble_memwb high exactly 3 cycles, state RUN→MEM_WAIT→RUN, stall_cnt=3.
- ex_branch_taken=1 with a RAW hazard present → flush_ifof=flush_ofex=1 for 1 cycle, bubble_ofex=0, flush_cnt=1.
- mem_ready held 0 for 70 cycles with MEM_TIMEOUT=64 → mem_timeout rises on cycle 64 and stays set after mem_ready=1.
- Assert resetn=0 during MEM_WAIT with sb[7]=1 → immediately all outputs 0, scoreboard=0; after release, state=RUN.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage in-order pipeline: scoreboard-based
// RAW/WAW interlock, data-memory wait sequencing, branch flush and stall statistics.
module pipe_hazard_ctrl #(
  parameter int NREGS       = 32,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             of_valid,
  input  logic [4:0]       of_rs1,
  input  logic [4:0]       of_rs2,
  input  logic             of_rs1_used,
  input  logic             of_rs2_used,
  input  logic [4:0]       of_rd,
  input  logic             of_rd_wr,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             wb_valid,
  input  logic             wb_rd_wr,
  input  logic [4:0]       wb_rd,
  output logic             stall_front,
  output logic             stall_back,
  output logic             bubble_ofex,
  output logic             bubble_memwb,
  output logic             flush_ifof,
  output logic             flush_ofex,
  output logic             issue,
  output logic [NREGS-1:0] scoreboard,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  localparam int              WC_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX   = WC_W'(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_ONE   = WC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [NREGS-1:0] ONE_HOT0 = NREGS'(1);

  logic [0:0]       state_r, state_next_s;
  logic [WC_W-1:0]  wait_cnt_r, wait_cnt_next_s;
  logic             mem_timeout_r;
  logic [NREGS-1:0] sb_r, sb_next_s, sb_eff_s, wb_clr_s, of_set_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
  logic             mem_stall_s, flush_s, raw_s, waw_s, hazard_s, issue_s;
  logic             wb_fire_s, stall_front_s;

  // A register retiring in WB this cycle is already visible through the write-through regfile.
  assign wb_fire_s = wb_valid & wb_rd_wr & (wb_rd != 5'd0);
  assign wb_clr_s  = wb_fire_s ? (ONE_HOT0 << wb_rd) : {NREGS{1'b0}};
  assign sb_eff_s  = sb_r & ~wb_clr_s;

  assign raw_s = (of_rs1_used & (of_rs1 != 5'd0) & sb_eff_s[of_rs1]) |
                 (of_rs2_used & (of_rs2 != 5'd0) & sb_eff_s[of_rs2]);
  assign waw_s = of_rd_wr & (of_rd != 5'd0) & sb_eff_s[of_rd];

  assign flush_s       = ~mem_stall_s & ex_branch_taken;
  assign hazard_s      = of_valid & ~mem_stall_s & ~flush_s & (raw_s | waw_s);
  assign issue_s       = of_valid & ~mem_stall_s & ~flush_s & ~(raw_s | waw_s);
  assign stall_front_s = mem_stall_s | hazard_s;

  assign of_set_s  = (issue_s & of_rd_wr & (of_rd != 5'd0)) ? (ONE_HOT0 << of_rd) : {NREGS{1'b0}};
  assign sb_next_s = (sb_r & ~wb_clr_s) | of_set_s;

  // Memory-wait FSM next state and stall decode.
  always_comb begin
    state_next_s = state_r;
    mem_stall_s  = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          mem_stall_s  = 1'b1;
          state_next_s = ST_MEM_WAIT;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_next_s = ST_RUN;
        end else begin
          mem_stall_s  = 1'b1;
          state_next_s = ST_MEM_WAIT;
        end
      end
      default: begin
        state_next_s = ST_RUN;
      end
    endcase
  end

  // Wait counter saturates at the timeout so the sticky flag cannot be missed by wrap-around.
  always_comb begin
    wait_cnt_next_s = {WC_W{1'b0}};
    if ((state_r == ST_MEM_WAIT) && !mem_ready) begin
      if (wait_cnt_r == WC_MAX) begin
        wait_cnt_next_s = wait_cnt_r;
      end else begin
        wait_cnt_next_s = wait_cnt_r + WC_ONE;
      end
    end else begin
      wait_cnt_next_s = {WC_W{1'b0}};
    end
  end

  // Control outputs are forced low while reset is asserted.
  always_comb begin
    stall_front  = 1'b0;
    stall_back   = 1'b0;
    bubble_ofex  = 1'b0;
    bubble_memwb = 1'b0;
    flush_ifof   = 1'b0;
    flush_ofex   = 1'b0;
    issue        = 1'b0;
    if (resetn) begin
      stall_front  = stall_front_s;
      stall_back   = mem_stall_s;
      bubble_ofex  = hazard_s;
      bubble_memwb = mem_stall_s;
      flush_ifof   = flush_s;
      flush_ofex   = flush_s;
      issue        = issue_s;
    end else begin
      issue        = 1'b0;
    end
  end

  // State, scoreboard, timeout flag and performance counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r       <= ST_RUN;
      wait_cnt_r    <= {WC_W{1'b0}};
      mem_timeout_r <= 1'b0;
      sb_r          <= {NREGS{1'b0}};
      stall_cnt_r   <= {CNT_W{1'b0}};
      flush_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_cnt_next_s;
      sb_r       <= sb_next_s;
      if ((state_r == ST_MEM_WAIT) && (wait_cnt_next_s == WC_MAX)) begin
        mem_timeout_r <= 1'b1;
      end
      if (stall_front_s) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (flush_s) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
    end
  end

  assign scoreboard  = sb_r;
  assign mem_timeout = mem_timeout_r;
  assign stall_cnt   = stall_cnt_r;
  assign flush_cnt   = flush_cnt_r;

endmodule
